bg_mean_calc: RTL and testbench

//  Upstream stage of the pe background-removal array. Streams in a sampled set of background

---
 rtl/bg_mean_calc_pkg.sv | 26 ++
 rtl/bg_mean_calc_divider.sv | 58 +++++
 rtl/bg_mean_calc.sv | 166 ++++++++++++++++
 tb/tb_bg_mean_calc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_mean_calc_pkg.sv
// Shared definitions for the background-mean stage and the pe that consumes its result.
// The state encoding is shared so the pe and its bench can decode the one-hot flags alike.
package bg_pkg;

    localparam int PIX_W          = 8;
    localparam int NUM_PIXELS_DEF = 25;
    localparam int ACC_WIDTH_DEF  = 16;
    localparam int CNT_WIDTH_DEF  = 8;

    localparam logic [1:0] QI   = 2'd0;
    localparam logic [1:0] QACC = 2'd1;
    localparam logic [1:0] QDIV = 2'd2;
    localparam logic [1:0] QD   = 2'd3;

    typedef struct packed {
        logic [PIX_W-1:0] red;
        logic [PIX_W-1:0] green;
        logic [PIX_W-1:0] blue;
    } rgb_t;

    // Smallest accumulator that cannot overflow for a given frame sample size.
    function automatic int min_acc_width(input int pixels);
        return PIX_W + $clog2(pixels);
    endfunction

endpackage

// File: rtl/bg_mean_calc_divider.sv
// Restoring divider producing one quotient bit per busy cycle, MSB first.
// The iteration count lives in the parent so several dividers can share one counter.
module seq_divider
    import bg_pkg::*;
#(
    parameter int WIDTH  = ACC_WIDTH_DEF,
    parameter int QUOT_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              busy,
    input  logic              last,
    input  logic [WIDTH-1:0]  dividend,
    input  logic [WIDTH-1:0]  divisor,
    output logic              done,
    output logic [QUOT_W-1:0] quotient
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dq_nxt;

    // dq starts as the dividend and fills with quotient bits as it shifts left.
    always_comb begin
        trial   = {rem, dq[WIDTH-1]};
        diff    = trial - {1'b0, dsr};
        fits    = ~diff[WIDTH];
        rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dq_nxt  = {dq[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            dq  <= '0;
            dsr <= '0;
        end else if (start) begin
            rem <= '0;
            dq  <= dividend;
            dsr <= divisor;
        end else if (busy) begin
            rem <= rem_nxt;
            dq  <= dq_nxt;
        end
    end

    // Quotient includes the bit being resolved this cycle, so the final value is
    // available on the same edge that retires the last iteration.
    assign done     = busy & last;
    assign quotient = busy ? dq_nxt[QUOT_W-1:0] : dq[QUOT_W-1:0];

endmodule

// File: rtl/bg_mean_calc.sv
// Accumulates a sampled set of background pixels and presents the per-channel mean.
//   state | meaning
//   QI    | idle, waiting for Start
//   QACC  | accepting pixels, summing channels
//   QDIV  | dividing sums by pixel count, ACC_WIDTH cycles
//   QD    | result valid, waiting for Ack
module bg_mean_calc
    import bg_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             In_Valid,
    input  logic             In_Last,
    input  logic [PIX_W-1:0] red_in,
    input  logic [PIX_W-1:0] green_in,
    input  logic [PIX_W-1:0] blue_in,
    output logic             In_Ready,
    output logic [PIX_W-1:0] red_exp,
    output logic [PIX_W-1:0] green_exp,
    output logic [PIX_W-1:0] blue_exp,
    output logic             Done,
    output logic             Qi,
    output logic             Qacc,
    output logic             Qdiv,
    output logic             Qd
);

    localparam int ITER_W = $clog2(ACC_WIDTH + 1);

    if (ACC_WIDTH < min_acc_width(NUM_PIXELS)) begin : g_acc_width_check
        $error("ACC_WIDTH too small for NUM_PIXELS");
    end
    if (NUM_PIXELS > (1 << CNT_WIDTH) - 1) begin : g_cnt_width_check
        $error("CNT_WIDTH cannot hold NUM_PIXELS");
    end

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] sum_r, sum_g, sum_b;
    logic [ACC_WIDTH-1:0] sum_r_nxt, sum_g_nxt, sum_b_nxt;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic [ITER_W-1:0]    iter;
    logic                 iter_tc;
    logic                 accept;
    logic                 pix_last;
    logic                 in_div;
    logic                 done_r, done_g, done_b;
    logic                 div_done;
    logic [PIX_W-1:0]     quot_r, quot_g, quot_b;
    rgb_t                 exp_q;

    assign accept    = (state == QACC) & In_Valid;
    assign sum_r_nxt = sum_r + ACC_WIDTH'(red_in);
    assign sum_g_nxt = sum_g + ACC_WIDTH'(green_in);
    assign sum_b_nxt = sum_b + ACC_WIDTH'(blue_in);
    assign count_nxt = count + 1'b1;
    assign pix_last  = accept & (In_Last | (count_nxt == CNT_WIDTH'(NUM_PIXELS)));
    assign in_div    = (state == QDIV);
    assign iter_tc   = (iter == '0);
    assign div_done  = done_r & done_g & done_b;

    // Dividers load the final sums on the accepting edge, so QDIV spends every
    // one of its ACC_WIDTH cycles resolving quotient bits.
    seq_divider #(.WIDTH(ACC_WIDTH), .QUOT_W(PIX_W)) u_div_r (
        .clk      (Clk),
        .rst_n    (Reset),
        .start    (pix_last),
        .busy     (in_div),
        .last     (iter_tc),
        .dividend (sum_r_nxt),
        .divisor  (ACC_WIDTH'(count_nxt)),
        .done     (done_r),
        .quotient (quot_r)
    );

    seq_divider #(.WIDTH(ACC_WIDTH), .QUOT_W(PIX_W)) u_div_g (
        .clk      (Clk),
        .rst_n    (Reset),
        .start    (pix_last),
        .busy     (in_div),
        .last     (iter_tc),
        .dividend (sum_g_nxt),
        .divisor  (ACC_WIDTH'(count_nxt)),
        .done     (done_g),
        .quotient (quot_g)
    );

    seq_divider #(.WIDTH(ACC_WIDTH), .QUOT_W(PIX_W)) u_div_b (
        .clk      (Clk),
        .rst_n    (Reset),
        .start    (pix_last),
        .busy     (in_div),
        .last     (iter_tc),
        .dividend (sum_b_nxt),
        .divisor  (ACC_WIDTH'(count_nxt)),
        .done     (done_b),
        .quotient (quot_b)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= QI;
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
            count <= '0;
            iter  <= '0;
            exp_q <= '0;
        end else begin
            case (state)
                QI: begin
                    if (Start) begin
                        state <= QACC;
                        sum_r <= '0;
                        sum_g <= '0;
                        sum_b <= '0;
                        count <= '0;
                    end
                end
                QACC: begin
                    if (accept) begin
                        sum_r <= sum_r_nxt;
                        sum_g <= sum_g_nxt;
                        sum_b <= sum_b_nxt;
                        count <= count_nxt;
                        if (pix_last) begin
                            state <= QDIV;
                            iter  <= ITER_W'(ACC_WIDTH - 1);
                        end
                    end
                end
                QDIV: begin
                    if (div_done) begin
                        exp_q <= '{red: quot_r, green: quot_g, blue: quot_b};
                        state <= QD;
                    end else begin
                        iter <= iter - 1'b1;
                    end
                end
                QD: begin
                    if (Ack) begin
                        state <= QI;
                    end
                end
                default: state <= QI;
            endcase
        end
    end

    assign Qi        = (state == QI);
    assign Qacc      = (state == QACC);
    assign Qdiv      = (state == QDIV);
    assign Qd        = (state == QD);
    assign In_Ready  = Qacc;
    assign Done      = Qd;
    assign red_exp   = exp_q.red;
    assign green_exp = exp_q.green;
    assign blue_exp  = exp_q.blue;

endmodule

// File: tb/tb_bg_mean_calc.sv
// Bench for bg_mean_calc: directed scenarios plus random frames, checked every cycle
// against a frame-level model that averages the accepted pixels with plain arithmetic.
module tb_bg_mean_calc;
    import bg_pkg::*;

    localparam int NPIX = 25;
    localparam int AW   = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       In_Valid = 1'b0;
    logic       In_Last = 1'b0;
    logic [7:0] red_in = '0;
    logic [7:0] green_in = '0;
    logic [7:0] blue_in = '0;
    logic       In_Ready;
    logic [7:0] red_exp, green_exp, blue_exp;
    logic       Done, Qi, Qacc, Qdiv, Qd;

    int n_cmp = 0;
    int n_bad = 0;

    bg_mean_calc #(.NUM_PIXELS(NPIX), .ACC_WIDTH(AW), .CNT_WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Ack       (Ack),
        .In_Valid  (In_Valid),
        .In_Last   (In_Last),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .In_Ready  (In_Ready),
        .red_exp   (red_exp),
        .green_exp (green_exp),
        .blue_exp  (blue_exp),
        .Done      (Done),
        .Qi        (Qi),
        .Qacc      (Qacc),
        .Qdiv      (Qdiv),
        .Qd        (Qd)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Frame-level model: 0 idle, 1 collecting, 2 dividing, 3 result presented.
    int         m_mode = 0;
    int         m_wait = 0;
    int         q_r[$];
    int         q_g[$];
    int         q_b[$];
    logic [23:0] m_exp = '0;

    function automatic logic [7:0] mean(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return 8'(s / q.size());
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_mode <= 0;
            m_wait <= 0;
            m_exp  <= '0;
            q_r.delete(); q_g.delete(); q_b.delete();
        end else begin
            case (m_mode)
                0: if (Start) begin
                    m_mode <= 1;
                    q_r.delete(); q_g.delete(); q_b.delete();
                end
                1: if (In_Valid) begin
                    q_r.push_back(int'(red_in));
                    q_g.push_back(int'(green_in));
                    q_b.push_back(int'(blue_in));
                    if (In_Last || q_r.size() == NPIX) begin
                        m_mode <= 2;
                        m_wait <= AW;
                    end
                end
                2: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) begin
                        m_exp  <= {mean(q_r), mean(q_g), mean(q_b)};
                        m_mode <= 3;
                    end
                end
                default: if (Ack) m_mode <= 0;
            endcase
        end
    end

    always @(negedge Clk) begin
        chk("flags", 64'({Qi, Qacc, Qdiv, Qd, In_Ready, Done}),
            64'({m_mode == 0, m_mode == 1, m_mode == 2, m_mode == 3, m_mode == 1, m_mode == 3}));
        chk("exp", 64'({red_exp, green_exp, blue_exp}), 64'(m_exp));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic start_frame();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic last);
        bit rdy;
        bit ok = 0;
        In_Valid = 1'b1;
        In_Last  = last;
        red_in   = r;
        green_in = g;
        blue_in  = b;
        for (int k = 0; k < 200; k++) begin
            rdy = In_Ready;
            tick(1);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 300) begin
            tick(1);
            n++;
        end
        if (!Done) chk("done_timeout", 64'(Done), 64'd1);
    endtask

    task automatic ack_frame();
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        bit use_last;

        tick(2);
        chk("reset_qi", 64'(Qi), 64'd1);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_exp", 64'({red_exp, green_exp, blue_exp}), 64'd0);
        #1 Reset = 1'b1;
        tick(1);

        // 1: single pixel, latency from acceptance to Done
        start_frame();
        send_pixel(8'd61, 8'd133, 8'd198, 1'b1);
        wait_done(n);
        chk("s1_latency", 64'(n), 64'(AW));
        chk("s1_exp", 64'({red_exp, green_exp, blue_exp}), 64'({8'd61, 8'd133, 8'd198}));
        ack_frame();

        // 2: full frame auto-terminates at 25
        start_frame();
        for (int i = 0; i < NPIX; i++) send_pixel(8'd10, 8'd10, 8'd10, 1'b0);
        chk("s2_ready_after_25", 64'(In_Ready), 64'd0);
        chk("s2_in_div", 64'(Qdiv), 64'd1);
        wait_done(n);
        chk("s2_exp", 64'({red_exp, green_exp, blue_exp}), 64'({8'd10, 8'd10, 8'd10}));
        ack_frame();

        // 3: truncation
        start_frame();
        send_pixel(8'd10, 8'($urandom), 8'($urandom), 1'b0);
        send_pixel(8'd11, 8'($urandom), 8'($urandom), 1'b0);
        send_pixel(8'd13, 8'($urandom), 8'($urandom), 1'b1);
        wait_done(n);
        chk("s3_red_34_3", 64'(red_exp), 64'd11);
        ack_frame();
        start_frame();
        for (int i = 0; i < NPIX; i++) send_pixel(8'(i), 8'($urandom), 8'($urandom), i == NPIX - 1);
        wait_done(n);
        chk("s3_ramp", 64'(red_exp), 64'd12);
        ack_frame();

        // 4: max value
        start_frame();
        for (int i = 0; i < NPIX; i++) send_pixel(8'd255, 8'd0, 8'd255, 1'b0);
        wait_done(n);
        chk("s4_max", 64'({red_exp, green_exp, blue_exp}), 64'({8'd255, 8'd0, 8'd255}));
        ack_frame();

        // 5: handshake and ignored inputs
        start_frame();
        send_pixel(8'd10, 8'd1, 8'd2, 1'b0);
        tick($urandom_range(1, 3));
        send_pixel(8'd11, 8'd3, 8'd4, 1'b0);
        tick($urandom_range(1, 3));
        send_pixel(8'd13, 8'd5, 8'd6, 1'b1);
        tick(2);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("s5_start_in_div", 64'(Qdiv), 64'd1);
        Ack = 1'b1;
        wait_done(n);
        chk("s5_gap_exp", 64'({red_exp, green_exp, blue_exp}), 64'({8'd11, 8'd3, 8'd4}));
        tick(1);
        chk("s5_ack_to_qi", 64'(Qi), 64'd1);
        Ack = 1'b0;
        start_frame();
        send_pixel(8'd200, 8'd100, 8'd50, 1'b0);
        chk("s5_exp_held", 64'(red_exp), 64'd11);
        send_pixel(8'd101, 8'd0, 8'd7, 1'b1);
        wait_done(n);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("s5_start_in_qd", 64'(Qd), 64'd1);
        chk("s5_second_exp", 64'({red_exp, green_exp, blue_exp}), 64'({8'd150, 8'd50, 8'd28}));
        ack_frame();

        // 6: reset mid-division
        start_frame();
        send_pixel(8'd50, 8'd60, 8'd70, 1'b1);
        tick(5);
        #1 Reset = 1'b0;
        #1;
        chk("s6_qi", 64'(Qi), 64'd1);
        chk("s6_qdiv", 64'(Qdiv), 64'd0);
        chk("s6_done", 64'(Done), 64'd0);
        chk("s6_exp", 64'({red_exp, green_exp, blue_exp}), 64'd0);
        #2 Reset = 1'b1;
        tick(1);
        start_frame();
        send_pixel(8'd61, 8'd133, 8'd198, 1'b1);
        wait_done(n);
        chk("s6_after_exp", 64'({red_exp, green_exp, blue_exp}), 64'({8'd61, 8'd133, 8'd198}));
        ack_frame();

        // random frames
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, NPIX);
            use_last = (len < NPIX) || ($urandom_range(0, 1) == 1);
            tick($urandom_range(0, 2));
            start_frame();
            for (int i = 0; i < len; i++) begin
                send_pixel(8'($urandom), 8'($urandom), 8'($urandom),
                           use_last && (i == len - 1));
                tick($urandom_range(0, 2));
            end
            wait_done(n);
            tick($urandom_range(0, 3));
            ack_frame();
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
